// File: rtl/risky_pkg.sv
// Shared control encodings, decode constants and state type for the execute sequencer.
package risky_pkg;

    typedef enum logic [2:0] {
        ALU_NOP        = 3'd0,
        ALU_READ       = 3'd1,
        ALU_WRITE_A    = 3'd2,
        ALU_WRITE_B    = 3'd3,
        ALU_WRITE_MODE = 3'd4
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        REG_NOP   = 2'd0,
        REG_READ  = 2'd1,
        REG_WRITE = 2'd2
    } reg_ctrl_e;

    localparam logic [6:0] OPCODE_OP = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic       F7B_ALT    = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_MODE,
        S_WB,
        S_ERR,
        S_DONE
    } state_e;

    function automatic logic is_legal(input logic [31:0] word);
        return word[6:0] == OPCODE_OP;
    endfunction

endpackage

// File: rtl/risky_exec_seq.sv
// Execute-stage sequencer: moves R-type operands, mode and result between
// the register file and the ALU over the shared tristate bus.
module risky_exec_seq
    import risky_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       inst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        alu_ctrl,
    output logic [1:0]        reg_ctrl,
    output logic [REG_AW-1:0] reg_addr,
    inout  logic [XLEN-1:0]   bus
);

    state_e      state, state_nx;
    logic [31:0] inst_q;
    logic        err_q;

    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7bit;
    logic        drive_bus;
    alu_ctrl_e   alu_c;
    reg_ctrl_e   reg_c;
    logic        unused_fields;

    assign rd    = inst_q[11:7];
    assign f3    = inst_q[14:12];
    assign rs1   = inst_q[19:15];
    assign rs2   = inst_q[24:20];
    assign f7bit = inst_q[30];
    assign unused_fields = &{1'b0, inst_q[31], inst_q[29:25]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            inst_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start)
                inst_q <= inst;
            if (state == S_ERR)
                err_q <= 1'b1;
            else if (state == S_DONE)
                err_q <= 1'b0;
        end
    end

    always_comb begin
        state_nx  = state;
        alu_c     = ALU_NOP;
        reg_c     = REG_NOP;
        reg_addr  = '0;
        drive_bus = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nx = is_legal(inst) ? S_LOAD_A : S_ERR;
            end
            S_LOAD_A: begin
                reg_c    = REG_READ;
                reg_addr = REG_AW'(rs1);
                alu_c    = ALU_WRITE_A;
                state_nx = S_LOAD_B;
            end
            S_LOAD_B: begin
                reg_c    = REG_READ;
                reg_addr = REG_AW'(rs2);
                alu_c    = ALU_WRITE_B;
                state_nx = S_LOAD_MODE;
            end
            S_LOAD_MODE: begin
                // Only cycle this block owns the bus; RF and ALU are both quiet.
                drive_bus = 1'b1;
                alu_c     = ALU_WRITE_MODE;
                state_nx  = S_WB;
            end
            S_WB: begin
                alu_c    = ALU_READ;
                reg_addr = REG_AW'(rd);
                reg_c    = (rd != 5'd0) ? REG_WRITE : REG_NOP;
                state_nx = S_DONE;
            end
            S_ERR: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                err      = err_q;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign alu_ctrl = alu_c;
    assign reg_ctrl = reg_c;
    assign bus = drive_bus ? {{(XLEN-4){1'b0}}, f7bit, f3} : 'z;

endmodule

// File: doc/risky_exec_seq.md
Name: risky_exec_seq

Overview:
- Execute-stage sequencer for R-type ALU instructions.
- Drives the shared 32-bit tristate bus, the ALU ctrl code and the register-file ctrl/address so that operands, mode and result move between the register file and the ALU.
- Sits upstream of the ALU: it is the only block that issues ALU ctrl codes.
- Takes one latched instruction per start pulse and reports done/err.

Parameters:
- XLEN, 32, data/bus width.
- REG_AW, 5, register-file address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- inst  input  32  instruction word; captured on accepted start.
- busy  output  1  high from the cycle after start acceptance until DONE is left.
- done  output  1  one-cycle pulse at completion.
- err  output  1  valid with done; 1 = instruction not executed (illegal opcode).
- alu_ctrl  output  3  ALU ctrl code: 0 NOP, 1 READ, 2 WRITE_A, 3 WRITE_B, 4 WRITE_MODE.
- reg_ctrl  output  2  register-file ctrl: 0 NOP, 1 READ (drives bus), 2 WRITE (samples bus).
- reg_addr  output  REG_AW  register-file address.
- bus  inout  XLEN  shared bus; driven by this block only in LOAD_MODE, else high-Z.

Behaviour:
- Clock/reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE; inst_q=0.
  - busy=0, done=0, err=0; alu_ctrl=0, reg_ctrl=0, reg_addr=0; bus high-Z.
- Output style: all outputs are Moore-decoded from the state register plus inst_q. Assertion of rst forces NOP/high-Z immediately, without waiting for a clock edge.
- Decode fields from inst_q:
  - opcode=[6:0], rd=[11:7], f3=[14:12], rs1=[19:15], rs2=[24:20], f7bit=[30].
  - Legal iff opcode==7'b0110011.
- IDLE: outputs NOP.
  - start=1: capture inst into inst_q. Go to LOAD_A if legal, else ERR.
- LOAD_A: reg_ctrl=READ, reg_addr=rs1, alu_ctrl=WRITE_A. ALU latches A at the edge ending this cycle. Next LOAD_B.
- LOAD_B: reg_ctrl=READ, reg_addr=rs2, alu_ctrl=WRITE_B. Next LOAD_MODE.
- LOAD_MODE: bus={28'b0, f7bit, f3}, alu_ctrl=WRITE_MODE, reg_ctrl=NOP. Next WB.
- WB: alu_ctrl=READ, reg_addr=rd.
  - reg_ctrl=WRITE if rd!=0, else NOP (x0 never written).
  - ALU result is combinational from A/B/mode, so it is valid this cycle.
  - Next DONE.
- ERR: no bus, ALU or register-file activity. Next DONE with err_q=1.
- DONE: done=1, err=err_q, all ctrl NOP. Next IDLE; err_q clears on leaving.
- Latency:
  - Legal instruction: start edge → done high 5 cycles later (LOAD_A, LOAD_B, LOAD_MODE, WB, DONE).
  - Illegal instruction: done 2 cycles after the start edge.
- Back-to-back: start is accepted in the IDLE cycle after DONE, so minimum issue interval is 6 cycles.
- start while busy or in DONE: ignored, not queued. inst_q is unchanged.
- Bus contention rule:
  - At most one driver per cycle. This block drives only in LOAD_MODE, during which reg_ctrl=NOP and alu_ctrl≠READ.
  - Exactly one bus source is active in each of LOAD_A, LOAD_B and WB.
- Same register on both ports (rs1==rs2, or rd==rs1): legal. The register file is read in LOAD_A/LOAD_B before the WB write.
- Reset mid-operation: sequence abandoned, no done pulse. Any partially loaded ALU A/B/mode is left as is (don't-care).

Decomposition:
- Package risky_pkg holds:
  - ALU ctrl codes (NOP/READ/WRITE_A/WRITE_B/WRITE_MODE).
  - Register-file ctrl codes.
  - OPCODE_OP=7'b0110011.
  - F3/F7 field constants.
  - State encoding typedef.
- Single module; no sub-module needed. The bench provides a behavioural register-file model plus the existing ALU.

Test Plan:
- x1=5, x2=7; inst=0x002081B3 (add x3,x1,x2), start → done at start+5 with err=0; x3==32'd12; bus never multiply driven (no X on bus).
- Same regs; inst=0x402081B3 (sub) → x3==32'hFFFFFFFE; mode written as 4'b1000 in LOAD_MODE.
- inst=0x00208033 (add x0,x1,x2) → done at +5; reg_ctrl never WRITE; x0 stays 0.
- inst=0x00500093 (OP-IMM opcode) → done at +2 with err=1; alu_ctrl and reg_ctrl stay NOP throughout.
- start held high for 10 cycles with add then sub encodings switching → first instruction completes unaffected; second accepted only in the IDLE cycle after DONE.
- Assert rst during LOAD_B → all ctrl NOP and bus high-Z before the next clk edge; no done pulse; fresh add after release gives the correct result.
